bus_turnaround_ctrl: RTL and testbench

BUS_TURNAROUND_CTRL -- requirements
Module: bus_turnaround_ctrl

---
 rtl/bus_turnaround_ctrl_pkg.sv | 14 +
 rtl/Tristate_Buffer.sv | 11 +
 rtl/bus_turnaround_ctrl.sv | 102 ++++++++++
 tb/tb_bus_turnaround_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bus_turnaround_ctrl_pkg.sv
// Shared types and constants for the bus turnaround controller.
// Holds the FSM state encoding and the cycle-counter width.
package bus_turnaround_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } state_t;

endpackage

// File: rtl/Tristate_Buffer.sv
// Single-bit tristate output stage: drives "in" onto "out" while "en" is high.
// Instantiated once per bus bit outside the controller.
module Tristate_Buffer (
  input  logic in,
  input  logic en,
  output tri   out
);

  assign out = en ? in : 1'bz;

endmodule

// File: rtl/bus_turnaround_ctrl.sv
// Shared-bus turnaround controller: drives writes, inserts release cycles, samples reads.
// Optional macro BUS_READBACK_CHK_EN adds a sticky bus_err contention flag.
module bus_turnaround_ctrl
  import bus_turnaround_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DRIVE_CYCLES = 2,
  parameter int TURN_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  input  logic [WIDTH-1:0] bus_in,
`ifdef BUS_READBACK_CHK_EN
  output logic             bus_err,
`endif
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             is_read;
  logic             accept;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign bus_en    = (state == DRIVE);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_write ? DRIVE : TURN;
          cnt_next   = req_write ? DRIVE_LAST : TURN_LAST;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_next = TURN;
          cnt_next   = TURN_LAST;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      TURN: begin
        if (cnt == '0) begin
          state_next = is_read ? SAMPLE : IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SAMPLE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; all registers here are
  // small and reset asynchronously so a mid-transaction rst leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_read   <= 1'b0;
      bus_out   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rsp_valid <= (state == SAMPLE);
      if (state == SAMPLE) rsp_data <= bus_in;
      if (accept) begin
        is_read <= !req_write;
        if (req_write) bus_out <= req_data;
      end
    end
  end

`ifdef BUS_READBACK_CHK_EN
  // Readback mismatch while we own the bus means another driver is fighting us.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((state == DRIVE) && (bus_in != bus_out)) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_turnaround_ctrl.sv
// Self-checking bench for bus_turnaround_ctrl: directed scenarios plus random
// transactions compared against a latency/sequence model of the protocol.
module tb_bus_turnaround_ctrl;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int T  = 1;
  localparam int D2 = 4;
  localparam int T2 = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [W-1:0] req_data = '0;
  logic         req_ready, bus_en, rsp_valid;
  logic [W-1:0] bus_out, rsp_data, bus_in;
  wire  [W-1:0] bus_pad;
  logic         ext_en = 1'b0;
  logic [W-1:0] ext_data = '0;

  logic         rv2 = 1'b0;
  logic [W-1:0] rd2 = '0;
  logic         ready2, bus_en2, rsp_valid2;
  logic [W-1:0] bus_out2, rsp_data2;

`ifdef BUS_READBACK_CHK_EN
  logic bus_err, bus_err2;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] exp_bus_out = '0;
  logic [W-1:0] exp_rsp     = '0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_tri
    Tristate_Buffer u_tri (.in(bus_out[i]), .en(bus_en), .out(bus_pad[i]));
  end
  // An enabled external driver overrides the pad value.
  assign bus_in = ext_en ? ext_data : bus_pad;

  bus_turnaround_ctrl #(.WIDTH(W), .DRIVE_CYCLES(D), .TURN_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_data(req_data), .bus_out(bus_out), .bus_en(bus_en),
    .bus_in(bus_in),
`ifdef BUS_READBACK_CHK_EN
    .bus_err(bus_err),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  bus_turnaround_ctrl #(.WIDTH(W), .DRIVE_CYCLES(D2), .TURN_CYCLES(T2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(ready2),
    .req_write(1'b1), .req_data(rd2), .bus_out(bus_out2), .bus_en(bus_en2),
    .bus_in(bus_out2),
`ifdef BUS_READBACK_CHK_EN
    .bus_err(bus_err2),
`endif
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the default instance, entered and left at a negedge in an IDLE cycle.
  task automatic txn(input logic wr, input logic [W-1:0] data, input logic [W-1:0] ext);
    int lat;
    lat = wr ? D + T + 1 : T + 2;
    check("ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_data  = data;
    ext_en    = !wr;
    ext_data  = ext;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = ~data;
    if (wr) exp_bus_out = data;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("bus_en", bus_en, (wr && k <= D) ? 1 : 0);
      check("req_ready", req_ready, (k == lat) ? 1 : 0);
      check("rsp_valid", rsp_valid, (!wr && k == lat) ? 1 : 0);
      check("bus_out", bus_out, exp_bus_out);
      if (!wr && k == lat) exp_rsp = ext;
      check("rsp_data", rsp_data, exp_rsp);
    end
    ext_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_data  = W'($urandom);
      @(negedge clk);
      check("idle_ready", req_ready, 1);
      check("idle_bus_en", bus_en, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_bus_out", bus_out, exp_bus_out);
      check("idle_rsp_data", rsp_data, exp_rsp);
    end
  endtask

  initial begin
    #2;
    check("rst_ready", req_ready, 1);
    check("rst_bus_en", bus_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);

    txn(1'b1, 8'hA5, 8'h00);
    txn(1'b0, 8'h00, 8'h3C);
    idle_cycles(2);
    txn(1'b1, 8'h11, 8'h00);
    txn(1'b0, 8'h00, 8'hC3);
    idle_cycles(1);

    // Reset during the second DRIVE cycle.
    req_valid = 1'b1; req_write = 1'b1; req_data = 8'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_drive_bus_en", bus_en, 1);
    rst = 1'b1;
    #1;
    check("rst_async_bus_en", bus_en, 0);
    check("rst_async_ready", req_ready, 1);
    check("rst_async_bus_out", bus_out, 0);
    check("rst_async_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_bus_out = '0;
    exp_rsp     = '0;
    idle_cycles(3);

    // Long-drive, long-turn instance.
    rv2 = 1'b1; rd2 = 8'h5A;
    @(posedge clk);
    #1 rv2 = 1'b0;
    for (int k = 1; k <= D2 + T2 + 1; k++) begin
      @(negedge clk);
      check("p2_bus_en", bus_en2, (k <= D2) ? 1 : 0);
      check("p2_ready", ready2, (k == D2 + T2 + 1) ? 1 : 0);
      check("p2_bus_out", bus_out2, 8'h5A);
    end

    for (int n = 0; n < 30; n++) begin
      txn(1'($urandom), W'($urandom), W'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

`ifdef BUS_READBACK_CHK_EN
    check("no_contention_err", bus_err, 0);
    ext_en = 1'b1; ext_data = 8'h00;
    req_valid = 1'b1; req_write = 1'b1; req_data = 8'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("contention_err", bus_err, 1);
    ext_en = 1'b0;
    repeat (5) @(negedge clk);
    check("contention_sticky", bus_err, 1);
    rst = 1'b1;
    #1;
    check("contention_clear", bus_err, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
